// File: rtl/snake_pkg.sv
// snake_pkg: shared direction codes, tick FSM states and grid defaults for the snake head logic.
package snake_pkg;
    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tick_state_t;
    localparam int GRID_W_DEF = 16;
    localparam int GRID_H_DEF = 16;
    // Opposite directions differ only in the upper code bit.
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction
endpackage

// File: rtl/move_tick_gen.sv
// move_tick_gen: divides clk down to a one-cycle move tick while enabled; pausing clears the count.
module move_tick_gen
    import snake_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    tick_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end
    // The enabling cycle in IDLE counts as count 0, so RUN resumes at 1.
    always_comb begin
        state_n = enable ? RUN : IDLE;
        tick    = state == RUN && enable && cnt == LAST;
        cnt_n   = !enable ? '0 : state == IDLE ? CW'(1) : tick ? '0 : cnt + CW'(1);
    end
endmodule

// File: rtl/snake_head_mover.sv
// snake_head_mover: queues direction requests and steps the snake head one wrapped grid cell per move tick.
module snake_head_mover
    import snake_pkg::*;
#(
    parameter int GRID_W   = GRID_W_DEF,
    parameter int GRID_H   = GRID_H_DEF,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [1:0]                snakeDirection,
    output logic [$clog2(GRID_W)-1:0] head_x,
    output logic [$clog2(GRID_H)-1:0] head_y,
    output logic [1:0]                heading,
    output logic                      step
);
    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam logic [XW-1:0] XMAX = XW'(GRID_W - 1);
    localparam logic [YW-1:0] YMAX = YW'(GRID_H - 1);
    logic tick, req, pop, push;
    logic [1:0] fill, fill_n, wr;
    dir_t sd, dir_prev, q0, q1, q0_n, q1_n, hd, hd_n;
    logic [XW-1:0] x_n;
    logic [YW-1:0] y_n;
    move_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );
    assign sd      = dir_t'(snakeDirection);
    assign heading = hd;
    // q0 is the FIFO head; a push lands in the first free slot left after any pop.
    always_comb begin
        req    = sd != dir_prev;
        pop    = tick && fill != 2'd0;
        push   = req && (fill != 2'd2 || pop);
        wr     = fill - {1'b0, pop};
        q0_n   = push && wr == 2'd0 ? sd : pop ? q1 : q0;
        q1_n   = push && wr == 2'd1 ? sd : q1;
        fill_n = fill + {1'b0, push} - {1'b0, pop};
        hd_n   = pop && q0 != opposite(hd) ? q0 : hd;
        x_n    = !tick ? head_x
               : hd_n == DIR_LEFT  ? (head_x == '0 ? XMAX : head_x - XW'(1))
               : hd_n == DIR_RIGHT ? (head_x == XMAX ? '0 : head_x + XW'(1))
               : head_x;
        y_n    = !tick ? head_y
               : hd_n == DIR_UP   ? (head_y == '0 ? YMAX : head_y - YW'(1))
               : hd_n == DIR_DOWN ? (head_y == YMAX ? '0 : head_y + YW'(1))
               : head_y;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            dir_prev <= DIR_UP;
            q0       <= DIR_UP;
            q1       <= DIR_UP;
            fill     <= 2'd0;
            hd       <= DIR_UP;
            head_x   <= XW'(GRID_W / 2);
            head_y   <= YW'(GRID_H / 2);
            step     <= 1'b0;
        end else begin
            dir_prev <= sd;
            q0       <= q0_n;
            q1       <= q1_n;
            fill     <= fill_n;
            hd       <= hd_n;
            head_x   <= x_n;
            head_y   <= y_n;
            step     <= tick;
        end
    end
endmodule

// File: tb/tb_snake_head_mover.sv
// tb_snake_head_mover: directed and random stimulus against a queue-based reference model of the head mover.
module tb_snake_head_mover;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int TD = 4;
    logic clk = 1'b0;
    logic reset, enable;
    logic [1:0] dir;
    logic [2:0] head_x, head_y;
    logic [1:0] heading;
    logic step;
    int n_chk = 0;
    int n_fail = 0;
    int mx, my, mh, mprev, mcnt;
    bit mstep;
    int q[$];
    always #5 clk = ~clk;
    snake_head_mover #(.GRID_W(W), .GRID_H(H), .TICK_DIV(TD)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .snakeDirection (dir),
        .head_x         (head_x),
        .head_y         (head_y),
        .heading        (heading),
        .step           (step)
    );
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask
    // Reference: ticks every TD enabled cycles, FIFO as a queue, wrap by modulo.
    task automatic model();
        bit t;
        int d;
        if (reset) begin
            mx = W / 2; my = H / 2; mh = 0; mstep = 0;
            q.delete(); mprev = 0; mcnt = 0;
        end else begin
            t = enable && mcnt == TD - 1;
            if (t && q.size() > 0) begin
                d = q.pop_front();
                if (d != (mh ^ 2)) mh = d;
            end
            if (t) begin
                if (mh == 0) my = (my + H - 1) % H;
                if (mh == 2) my = (my + 1) % H;
                if (mh == 1) mx = (mx + W - 1) % W;
                if (mh == 3) mx = (mx + 1) % W;
            end
            mstep = t;
            if (int'(dir) != mprev && q.size() < 2) q.push_back(int'(dir));
            mprev = int'(dir);
            mcnt = enable ? (mcnt + 1) % TD : 0;
        end
    endtask
    task automatic cycle();
        @(posedge clk);
        model();
        #1;
        check("head_x", head_x, mx);
        check("head_y", head_y, my);
        check("heading", heading, mh);
        check("step", step, mstep);
    endtask
    task automatic wait_step(output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!step && n < 20);
        if (!step) check("step_timeout", 0, 1);
    endtask
    initial begin
        int n;
        reset = 1'b1; enable = 1'b0; dir = 2'b00;
        cycle(); cycle();
        check("rst_x", head_x, 4);
        check("rst_y", head_y, 4);
        check("rst_step", step, 0);
        reset = 1'b0; enable = 1'b1;
        wait_step(n);
        check("t1_first_lat", n, 4);
        check("t1_y", head_y, 3);
        for (int k = 1; k < 5; k++) begin
            wait_step(n);
            check("t1_period", n, 4);
            check("t1_y", head_y, (3 - k + H) % H);
            check("t1_x", head_x, 4);
        end
        dir = 2'b10;
        wait_step(n);
        check("t2_heading", heading, 0);
        check("t2_y", head_y, 6);
        dir = 2'b11; cycle();
        dir = 2'b10; cycle();
        wait_step(n);
        check("t3_tick1", heading, 3);
        wait_step(n);
        check("t3_tick2", heading, 2);
        dir = 2'b01; cycle();
        dir = 2'b11; cycle();
        dir = 2'b00; cycle();
        wait_step(n);
        wait_step(n);
        wait_step(n);
        enable = 1'b0;
        repeat (20) cycle();
        enable = 1'b1;
        wait_step(n);
        check("t5_resume_lat", n, 4);
        dir = 2'b01; cycle();
        dir = 2'b11; cycle();
        reset = 1'b1; dir = 2'b00;
        cycle();
        reset = 1'b0;
        check("t6_x", head_x, 4);
        check("t6_y", head_y, 4);
        check("t6_heading", heading, 0);
        wait_step(n);
        check("t6_up_y", head_y, 3);
        wait_step(n);
        check("t6_up_y2", head_y, 2);
        check("t6_up_x", head_x, 4);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) dir = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 63) == 0) enable = ~enable;
            reset = $urandom_range(0, 499) == 0;
            cycle();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
